// File: rtl/config_ram_initiator.sv
// -----------------------------------------------------------------------------
// config_ram_initiator
//
// Single-outstanding command initiator in front of a simple word RAM.
// After reset it clears the whole RAM with a write sweep, then accepts one
// read/write command at a time and returns exactly one response per command.
//
// Ports
//   CLK, nRST             clock (rising edge), asynchronous active-low reset
//   cmd_*                 command channel (valid/ready handshake)
//   rsp_*                 response channel (valid/ready handshake)
//   init_done             high once the clear sweep has finished, until reset
//   wdata/addr/byte_en    RAM request fields
//   wen/ren               RAM write/read request (never both high)
//   rdata                 RAM read data, sampled on the completing edge
//   busy                  RAM stall; a request completes on an edge where it
//                         is high and busy is low
//
// Every output is a register, so nothing coming back from the RAM (busy,
// rdata) has a combinational path onto the RAM request outputs.
// -----------------------------------------------------------------------------
module config_ram_initiator #(
    parameter int N_BYTES   = 4,
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = $clog2(DEPTH),
    parameter int N_BITS    = N_BYTES * 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    // command channel
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [N_BITS-1:0]    cmd_wdata,
    input  logic [N_BYTES-1:0]   cmd_byte_en,
    // response channel
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N_BITS-1:0]    rsp_rdata,
    output logic                 rsp_is_read,
    // status
    output logic                 init_done,
    // RAM side
    output logic [N_BITS-1:0]    wdata,
    output logic [ADDR_BITS-1:0] addr,
    output logic [N_BYTES-1:0]   byte_en,
    output logic                 wen,
    output logic                 ren,
    input  logic [N_BITS-1:0]    rdata,
    input  logic                 busy
);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // One bit wider than the address so a power-of-two DEPTH ends the sweep
    // without the counter wrapping back to zero.
    localparam logic [ADDR_BITS:0] LAST_WORD = (ADDR_BITS + 1)'(DEPTH - 1);

    state_t               state_reg;
    logic [ADDR_BITS:0]   sweep_count_reg;
    logic [ADDR_BITS:0]   sweep_count_next;

    assign sweep_count_next = sweep_count_reg + 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // Reset lands directly in the first sweep write (addr 0, data 0).
            state_reg       <= INIT;
            sweep_count_reg <= '0;
            wen             <= 1'b1;
            ren             <= 1'b0;
            addr            <= '0;
            wdata           <= '0;
            byte_en         <= '1;
            cmd_ready       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_is_read     <= 1'b0;
            init_done       <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    // wdata and byte_en keep their reset values (0 / all ones)
                    // for the whole sweep; only the address advances.
                    if (!busy) begin
                        if (sweep_count_reg == LAST_WORD) begin
                            state_reg <= IDLE;
                            wen       <= 1'b0;
                            init_done <= 1'b1;
                            cmd_ready <= 1'b1;
                        end else begin
                            sweep_count_reg <= sweep_count_next;
                            addr            <= sweep_count_next[ADDR_BITS-1:0];
                        end
                    end
                end

                IDLE: begin
                    // cmd_ready is high throughout IDLE, so cmd_valid alone
                    // completes the handshake here.
                    if (cmd_valid) begin
                        state_reg <= ACCESS;
                        cmd_ready <= 1'b0;
                        addr      <= cmd_addr;
                        wdata     <= cmd_wdata;
                        byte_en   <= cmd_byte_en;
                        wen       <= cmd_write;
                        ren       <= !cmd_write;
                    end
                end

                ACCESS: begin
                    // Request fields are held untouched while busy is high.
                    if (!busy) begin
                        state_reg   <= RESP;
                        wen         <= 1'b0;
                        ren         <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_is_read <= ren;
                        rsp_rdata   <= ren ? rdata : '0;
                    end
                end

                RESP: begin
                    // cmd_ready rises only after the response is taken, so a
                    // new command can never be accepted in the same cycle.
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_ram_initiator.sv
// -----------------------------------------------------------------------------
// tb_config_ram_initiator
//
// Drives config_ram_initiator against a behavioural byte-enabled RAM with a
// controllable busy stall. Expected read data comes from a word-level
// reference memory updated with mask arithmetic on every write command.
// -----------------------------------------------------------------------------
module tb_config_ram_initiator;

    localparam int N_BYTES   = 4;
    localparam int DEPTH     = 256;
    localparam int ADDR_BITS = 8;
    localparam int N_BITS    = 32;

    logic                 CLK = 1'b0;
    logic                 nRST = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic                 cmd_write = 1'b0;
    logic [ADDR_BITS-1:0] cmd_addr = '0;
    logic [N_BITS-1:0]    cmd_wdata = '0;
    logic [N_BYTES-1:0]   cmd_byte_en = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [N_BITS-1:0]    rsp_rdata;
    logic                 rsp_is_read;
    logic                 init_done;
    logic [N_BITS-1:0]    wdata;
    logic [ADDR_BITS-1:0] addr;
    logic [N_BYTES-1:0]   byte_en;
    logic                 wen;
    logic                 ren;
    logic [N_BITS-1:0]    rdata;
    logic                 busy = 1'b0;

    config_ram_initiator #(
        .N_BYTES  (N_BYTES),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_byte_en(cmd_byte_en),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_is_read(rsp_is_read),
        .init_done  (init_done),
        .wdata      (wdata),
        .addr       (addr),
        .byte_en    (byte_en),
        .wen        (wen),
        .ren        (ren),
        .rdata      (rdata),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Behavioural RAM: combinational read, byte-enabled write on a
    // completing edge (request high, busy low).
    logic [N_BITS-1:0] ram [DEPTH];
    assign rdata = ram[addr];
    always @(posedge CLK) begin
        if (wen && !busy) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (byte_en[b]) ram[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    logic both_seen = 1'b0;
    always @(negedge CLK) begin
        if (wen && ren) both_seen <= 1'b1;
    end

    // Reference memory of what every word should hold.
    logic [N_BITS-1:0] ref_mem [DEPTH];

    function automatic logic [N_BITS-1:0] lane_mask(input logic [N_BYTES-1:0] be);
        logic [N_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < N_BYTES; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [N_BITS-1:0] obs, input logic [N_BITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_wen", wen, 1'b1);
        chk("rst_ren", ren, 1'b0);
        chk("rst_addr", addr, '0);
        chk("rst_wdata", wdata, '0);
        chk("rst_byte_en", byte_en, 4'hF);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_rsp_is_read", rsp_is_read, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
    endtask

    // Called at a negedge right after nRST is released. Follows the clear
    // sweep, checking each write address in order; returns edges taken and
    // the number of completed sweep writes.
    task automatic follow_sweep(input bit random_busy, output int edges, output int done_words);
        int bad;
        bad = 0;
        edges = 0;
        done_words = 0;
        while (!init_done && edges < 4000) begin
            if (wen !== 1'b1 || ren !== 1'b0 || wdata !== '0 || byte_en !== 4'hF ||
                addr !== done_words[ADDR_BITS-1:0] || rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
                bad++;
            busy = random_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            @(posedge CLK);
            if (!busy) done_words++;
            @(negedge CLK);
            edges++;
        end
        busy = 1'b0;
        chk("sweep_init_done", init_done, 1'b1);
        chk("sweep_bad_cycles", bad, 0);
        chk("sweep_words", done_words, DEPTH);
        chk("sweep_wen_off", wen, 1'b0);
        chk("sweep_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // One complete command/response transaction. busy_cycles stalls the RAM
    // request that many edges; hold_cycles delays rsp_ready. lat is the
    // number of clock periods from the accepting edge to the first sample
    // point that shows rsp_valid.
    task automatic run_txn(input logic wr, input logic [ADDR_BITS-1:0] a,
                           input logic [N_BITS-1:0] d, input logic [N_BYTES-1:0] be,
                           input int busy_cycles, input int hold_cycles,
                           output logic [N_BITS-1:0] got, output int lat);
        int n;
        int req;
        logic stable;
        logic ok;
        logic [ADDR_BITS-1:0] a0;
        logic [N_BITS-1:0] exp;
        logic [N_BITS-1:0] held;

        @(negedge CLK);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_addr    = a;
        cmd_wdata   = d;
        cmd_byte_en = be;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        @(posedge CLK);
        #1;
        // Scramble the command inputs so only the latched copy can be used.
        cmd_valid   = 1'b0;
        cmd_write   = 1'($urandom);
        cmd_addr    = ADDR_BITS'($urandom);
        cmd_wdata   = $urandom;
        cmd_byte_en = N_BYTES'($urandom);

        lat = 0;
        req = 0;
        stable = 1'b1;
        a0 = '0;
        while (lat < 100) begin
            @(negedge CLK);
            lat++;
            if (rsp_valid) break;
            if (cmd_ready !== 1'b0) stable = 1'b0;
            if (wen || ren) begin
                req++;
                if (req == 1) a0 = addr;
                else if (addr !== a0) stable = 1'b0;
                if (wen !== wr || ren !== !wr || wdata !== d || byte_en !== be) stable = 1'b0;
            end
            busy = (req >= 1 && req <= busy_cycles);
        end
        // busy is meaningless in RESP; wiggle it to prove that.
        busy = 1'($urandom);

        exp = wr ? '0 : ref_mem[a];
        got = rsp_rdata;
        chk("rsp_valid_rise", rsp_valid, 1'b1);
        chk("req_cycles", req, busy_cycles + 1);
        chk("req_stable", {stable, a0}, {1'b1, a});
        chk("rsp_rdata", rsp_rdata, exp);
        chk("rsp_is_read", rsp_is_read, !wr);
        chk("rsp_ram_idle", {wen, ren, cmd_ready}, 3'b000);

        held = rsp_rdata;
        ok = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge CLK);
            busy = 1'($urandom);
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || rsp_is_read !== !wr || cmd_ready !== 1'b0)
                ok = 1'b0;
        end
        if (hold_cycles > 0) chk("rsp_held", ok, 1'b1);

        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        busy = 1'b0;
        @(negedge CLK);
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("cmd_ready_back", cmd_ready, 1'b1);

        if (wr) ref_mem[a] = (ref_mem[a] & ~lane_mask(be)) | (d & lane_mask(be));
        txn_no++;
        $display("txn %0d %s addr=%02h wdata=%08h be=%h busy=%0d hold=%0d rdata=%08h exp=%08h lat=%0d",
                 txn_no, wr ? "WR" : "RD", a, d, be, busy_cycles, hold_cycles, got, exp, lat);
    endtask

    initial begin
        logic [N_BITS-1:0] got;
        int lat;
        int edges;
        int words;
        int n;
        logic rsp_seen;

        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;

        // Reset state
        @(negedge CLK);
        check_reset_values();
        @(negedge CLK);
        nRST = 1'b1;

        // Clear sweep with no stalls: exactly DEPTH edges
        follow_sweep(1'b0, edges, words);
        chk("sweep_edges", edges, DEPTH);

        // Every word reads back zero
        for (int i = 0; i < DEPTH; i++) begin
            run_txn(1'b0, ADDR_BITS'(i), '0, '0, 0, 0, got, lat);
        end

        // Full write then read, minimum latency
        run_txn(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0, got, lat);
        chk("write_rdata_zero", got, '0);
        run_txn(1'b0, 8'h10, '0, '0, 0, 0, got, lat);
        chk("read_deadbeef", got, 32'hDEADBEEF);
        chk("read_latency", lat, 2);

        // Partial byte write merges into existing word
        run_txn(1'b1, 8'h10, 32'h11223344, 4'h2, 0, 0, got, lat);
        run_txn(1'b0, 8'h10, '0, '0, 0, 0, got, lat);
        chk("read_merged", got, 32'hDEAD33EF);

        // RAM stall of 3 cycles during a read
        run_txn(1'b0, 8'h10, '0, '0, 3, 0, got, lat);
        chk("stalled_read", got, 32'hDEAD33EF);

        // Response back-pressure for 5 cycles
        run_txn(1'b0, 8'h10, '0, '0, 0, 5, got, lat);
        chk("held_read", got, 32'hDEAD33EF);

        // byte_en = 0 write is still issued and answered, word unchanged
        run_txn(1'b1, 8'h20, 32'hCAFEF00D, 4'h0, 1, 1, got, lat);
        run_txn(1'b0, 8'h20, '0, '0, 0, 0, got, lat);
        chk("be0_unchanged", got, '0);

        // Randomized traffic against the reference memory
        for (int t = 0; t < 60; t++) begin
            run_txn(1'($urandom), ADDR_BITS'($urandom_range(0, 15)), $urandom,
                    N_BYTES'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), got, lat);
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk("ram_contents", ram[i], ref_mem[i]);
        end

        // Reset in the middle of a stalled read
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        busy = 1'b1;
        @(negedge CLK);
        chk("mid_access_ren", {ren, addr}, {1'b1, 8'h10});
        rsp_seen = 1'b0;
        nRST = 1'b0;
        #1;
        check_reset_values();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (rsp_valid) rsp_seen = 1'b1;
        end
        busy = 1'b0;
        nRST = 1'b1;
        follow_sweep(1'b1, edges, words);
        chk("no_rsp_after_reset", rsp_seen, 1'b0);

        // Memory is cleared again
        for (int t = 0; t < 8; t++) begin
            run_txn(1'b0, ADDR_BITS'($urandom_range(0, 31)), '0, '0, $urandom_range(0, 2), 0, got, lat);
        end
        chk("wen_ren_exclusive", both_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
